alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
- Shares one alu_nbit instance among NREQ requesters using round-robin arbitration and valid/ready handshakes.
- Issues at most one operation per cycle to the combinational ALU.
- Captures the ALU result in a one-entry output register, tagged with the requester index.
- Sits between the requesting engines (sequencers, test drivers) and the shared arithmetic datapath.

Parameters:
- W, 4: operand/result width. Must be 4 for the current ALU; other values unsupported.
- NREQ, 4: number of requesters, 2..8.
- IDW, 2: requester-ID width. Must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept; at most one bit high.
- req_op  in  3*NREQ  packed opcode, requester i at [3i+2:3i].
- req_a  in  W*NREQ  packed operand A.
- req_b  in  W*NREQ  packed operand B.
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  consumer accepts the result.
- res_data  out  W  ALU result.
- res_cout  out  1  carry/no-borrow flag.
- res_id  out  IDW  index of the requester that issued the result.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NAND, 5 NOR, 6 XOR, 7 XNOR.
  - ALU drive: sel = op, zero-extended to the ALU sel width; control = (op==1).
- Reset: res_valid=0, res_data=0, res_cout=0, res_id=0, rr pointer=0. req_ready is 0 during the reset cycle.
- slot_free = !res_valid || res_ready.
- Arbitration (combinational):
  - When slot_free, grant the first i with req_valid[i]=1, searching from ptr upward, modulo NREQ.
  - req_ready = one-hot(grant) when slot_free and any req_valid; else 0.
  - req_ready depends on req_valid but req_valid must not depend on req_ready.
- Transfer: requester i transfers in cycle t when req_valid[i] && req_ready[i].
- Result capture at edge t:
  - res_data = ALU y, res_id = i, res_valid = 1.
  - res_cout = ALU cout for ops 0/1; forced 0 for ops 2-7.
- Result retire: if res_ready && res_valid and there is no new transfer, res_valid goes to 0. Other result fields hold their last value.
- Latency and throughput:
  - Latency is 1 cycle: request accepted at t, res_valid high from t+1.
  - Sustained throughput is 1 op/cycle while res_ready=1.
- Backpressure: res_valid=1 and res_ready=0 means all req_ready=0 and the result register holds stable.
- Pointer:
  - After a transfer from i, ptr = (i+1) mod NREQ.
  - With no transfer, ptr holds.
  - Guarantees no starvation: each continuously-valid requester is served within NREQ transfers.
- Requester payload (op, a, b) must be stable while req_valid is high and not yet accepted. A requester may not drop req_valid before it is accepted.
- Arithmetic:
  - SUB is a + ~b + 1, mod 2^W.
  - res_cout=1 on SUB means a >= b (no borrow).
  - ADD res_cout is the carry out of bit W-1.
- Simultaneous retire and accept in the same cycle: the new result overwrites, and res_valid stays 1.
- Reset mid-operation: any pending result is discarded and ptr returns to 0. Requests held across reset are re-arbitrated from requester 0.
- No requests: req_ready=0, no state change except result retirement.

Test Plan:
- Single ADD, NREQ=4: req_valid=0001, op=0, a=9, b=8, res_ready=1. Required: req_ready=0001 in cycle 0; cycle 1 shows res_valid=1, res_data=1, res_cout=1, res_id=0.
- SUB borrow: requester 2, op=1, a=3, b=5. Required: res_data=14, res_cout=0, res_id=2. Repeat with a=5, b=3: res_data=2, res_cout=1.
- Round-robin fairness: req_valid=1111 held, res_ready=1. Required: grants in order 0,1,2,3,0,1 on consecutive cycles, with res_id following one cycle later.
- Backpressure: produce a result, then hold res_ready=0 for 3 cycles with req_valid=0110. Required: req_ready=0000 and res_data/res_id stable. On res_ready=1, requester 1 is granted in that same cycle.
- Logic ops: op=2..7 with a=1100, b=1010. Required results in order: 1000, 1110, 0111, 0001, 0110, 1001, each with res_cout=0.
- Reset mid-stream: with res_valid=1 and ptr=2, assert rst for 1 cycle. Required: res_valid=0, and the next grant with req_valid=1111 goes to requester 0.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler that shares one combinational ALU among NREQ requesters.
// Each accepted operation lands in a one-entry result register, tagged with its requester id.

module alu_nbit #(
  parameter int W    = 4,
  parameter int SELW = 4
) (
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [SELW-1:0] sel,
  input  logic            control,
  output logic [W-1:0]    y,
  output logic            cout
);

  logic [W:0] arith_s;

  // Arithmetic core adds a to b, or to ~b with carry-in when control is set (subtract).
  always_comb begin
    arith_s = {1'b0, a} + {1'b0, b ^ {W{control}}} + {{W{1'b0}}, control};
    y       = '0;
    cout    = 1'b0;
    case (sel)
      SELW'(0), SELW'(1): begin
        y    = arith_s[W-1:0];
        cout = arith_s[W];
      end
      SELW'(2): y = a & b;
      SELW'(3): y = a | b;
      SELW'(4): y = ~(a & b);
      SELW'(5): y = ~(a | b);
      SELW'(6): y = a ^ b;
      SELW'(7): y = ~(a ^ b);
      default: begin
        y    = '0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

module alu_rr_scheduler #(
  parameter int W    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_data,
  output logic              res_cout,
  output logic [IDW-1:0]    res_id
);

  localparam int NPAD = 1 << IDW;

  logic [IDW-1:0]  ptr_r;
  logic [NPAD-1:0] valid_pad_s;
  logic [NPAD-1:0] grant_pad_s;
  logic [IDW:0]    cand_s;
  logic            grant_found_s;
  logic [IDW-1:0]  grant_idx_s;
  logic [IDW-1:0]  ptr_next_s;
  logic            slot_free_s;
  logic            fire_s;
  logic [2:0]      op_s;
  logic [W-1:0]    a_s;
  logic [W-1:0]    b_s;
  logic [W-1:0]    alu_y_s;
  logic            alu_cout_s;

  // Find the first valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    valid_pad_s             = '0;
    valid_pad_s[NREQ-1:0]   = req_valid;
    grant_found_s           = 1'b0;
    grant_idx_s             = '0;
    cand_s                  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s        = {1'b0, ptr_r} + (IDW+1)'(k);
      cand_s        = (cand_s >= (IDW+1)'(NREQ)) ? cand_s - (IDW+1)'(NREQ) : cand_s;
      grant_idx_s   = (!grant_found_s && valid_pad_s[cand_s[IDW-1:0]]) ? cand_s[IDW-1:0] : grant_idx_s;
      grant_found_s = grant_found_s | valid_pad_s[cand_s[IDW-1:0]];
    end
  end

  // Handshake: a grant is only offered when the result slot can take a new value.
  always_comb begin
    slot_free_s              = !res_valid || res_ready;
    fire_s                   = slot_free_s && grant_found_s && !rst;
    grant_pad_s              = '0;
    grant_pad_s[grant_idx_s] = fire_s;
    req_ready                = grant_pad_s[NREQ-1:0];
    ptr_next_s               = (grant_idx_s == IDW'(NREQ-1)) ? '0 : grant_idx_s + 1'b1;
    op_s                     = req_op[3*grant_idx_s +: 3];
    a_s                      = req_a[W*grant_idx_s +: W];
    b_s                      = req_b[W*grant_idx_s +: W];
  end

  alu_nbit #(.W(W), .SELW(4)) u_alu (
    .a       (a_s),
    .b       (b_s),
    .sel     ({1'b0, op_s}),
    .control (op_s == 3'd1),
    .y       (alu_y_s),
    .cout    (alu_cout_s)
  );

  // Result register and round-robin pointer; a new capture wins over retirement.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cout  <= 1'b0;
      res_id    <= '0;
      ptr_r     <= '0;
    end else if (fire_s) begin
      res_valid <= 1'b1;
      res_data  <= alu_y_s;
      res_cout  <= (op_s <= 3'd1) ? alu_cout_s : 1'b0;
      res_id    <= grant_idx_s;
      ptr_r     <= ptr_next_s;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end else begin
      res_valid <= res_valid;
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: a per-cycle reference model plus hand-computed checkpoints.

module tb_alu_rr_scheduler;

  localparam int W    = 4;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op;
  logic [W*NREQ-1:0] req_a;
  logic [W*NREQ-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_data;
  logic              res_cout;
  logic [IDW-1:0]    res_id;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit         m_init = 1'b0;
  logic       m_valid;
  logic [3:0] m_data;
  logic       m_cout;
  logic [1:0] m_id;
  int         m_ptr;
  int         g_upd;
  int         g_cmp;
  logic [3:0] exp_rdy;
  logic [4:0] alu_ref;

  always #5 clk = ~clk;

  alu_rr_scheduler #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_cout  (res_cout),
    .res_id    (res_id)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of one operation from plain integer arithmetic: {cout, y}.
  function automatic logic [4:0] model_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int s;
    case (op)
      3'd0: begin s = int'(a) + int'(b); return {(s >= 16), 4'(s % 16)}; end
      3'd1: begin s = int'(a) - int'(b); return {(s >= 0), 4'((s + 16) % 16)}; end
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, ~(a & b)};
      3'd5: return {1'b0, ~(a | b)};
      3'd6: return {1'b0, a ^ b};
      3'd7: return {1'b0, ~(a ^ b)};
      default: return 5'd0;
    endcase
  endfunction

  // Which requester is served this cycle under the round-robin rule, or -1.
  function automatic int model_grant();
    if (rst) return -1;
    if (m_valid && !res_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init  = 1'b1;
      m_valid = 1'b0;
      m_data  = 4'd0;
      m_cout  = 1'b0;
      m_id    = 2'd0;
      m_ptr   = 0;
    end else if (m_init) begin
      g_upd = model_grant();
      if (g_upd >= 0) begin
        alu_ref = model_alu(req_op[3*g_upd +: 3], req_a[4*g_upd +: 4], req_b[4*g_upd +: 4]);
        m_valid = 1'b1;
        m_data  = alu_ref[3:0];
        m_cout  = alu_ref[4];
        m_id    = 2'(g_upd);
        m_ptr   = (g_upd + 1) % NREQ;
      end else if (res_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      g_cmp   = model_grant();
      exp_rdy = 4'b0000;
      if (g_cmp >= 0) exp_rdy[g_cmp] = 1'b1;
      check("model_req_ready", 16'(req_ready), 16'(exp_rdy));
      check("model_res_valid", 16'(res_valid), 16'(m_valid));
      check("model_res_data",  16'(res_data),  16'(m_data));
      check("model_res_cout",  16'(res_cout),  16'(m_cout));
      check("model_res_id",    16'(res_id),    16'(m_id));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    req_op[3*i +: 3] = op;
    req_a[4*i +: 4]  = a;
    req_b[4*i +: 4]  = b;
  endtask

  logic [3:0] fair_rdy [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [1:0] fair_id  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [3:0] logic_y  [6] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", 16'(res_valid), 16'd0);
    check("rst_res_data",  16'(res_data),  16'd0);
    check("rst_res_id",    16'(res_id),    16'd0);
    tick();
    rst = 1'b0;

    // Single ADD from requester 0
    set_req(0, 3'd0, 4'd9, 4'd8);
    req_valid = 4'b0001;
    res_ready = 1'b1;
    @(negedge clk);
    check("add_ready", 16'(req_ready), 16'b0001);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("add_valid", 16'(res_valid), 16'd1);
    check("add_data",  16'(res_data),  16'd1);
    check("add_cout",  16'(res_cout),  16'd1);
    check("add_id",    16'(res_id),    16'd0);

    // SUB with and without borrow from requester 2
    tick();
    set_req(2, 3'd1, 4'd3, 4'd5);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("sub_borrow_data", 16'(res_data), 16'd14);
    check("sub_borrow_cout", 16'(res_cout), 16'd0);
    check("sub_borrow_id",   16'(res_id),   16'd2);
    set_req(2, 3'd1, 4'd5, 4'd3);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("sub_nb_data", 16'(res_data), 16'd2);
    check("sub_nb_cout", 16'(res_cout), 16'd1);

    // Serve requester 3 so the pointer wraps to 0
    set_req(3, 3'd0, 4'd0, 4'd0);
    req_valid = 4'b1000;
    tick();

    // Fairness with all requesters valid
    set_req(0, 3'd0, 4'd1, 4'd1);
    set_req(1, 3'd0, 4'd2, 4'd2);
    set_req(2, 3'd0, 4'd3, 4'd3);
    set_req(3, 3'd0, 4'd4, 4'd4);
    req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rr_ready", 16'(req_ready), 16'(fair_rdy[c]));
      if (c > 0) check("rr_res_id", 16'(res_id), 16'(fair_id[c-1]));
      tick();
    end
    req_valid = 4'b0000;
    @(negedge clk);
    check("rr_last_id", 16'(res_id), 16'd1);

    // Backpressure holds the result and blocks all grants
    set_req(0, 3'd0, 4'd7, 4'd7);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0110;
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_ready", 16'(req_ready), 16'd0);
      check("bp_data",  16'(res_data),  16'd14);
      check("bp_id",    16'(res_id),    16'd0);
      check("bp_valid", 16'(res_valid), 16'd1);
      tick();
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 16'(req_ready), 16'b0010);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("bp_release_id",   16'(res_id),   16'd1);
    check("bp_release_data", 16'(res_data), 16'd4);

    // Logic operations, carry always cleared
    for (int op = 2; op < 8; op++) begin
      set_req(0, 3'(op), 4'b1100, 4'b1010);
      req_valid = 4'b0001;
      tick();
      req_valid = 4'b0000;
      @(negedge clk);
      check("logic_data", 16'(res_data), 16'(logic_y[op-2]));
      check("logic_cout", 16'(res_cout), 16'd0);
    end

    // Reset with a pending result and ptr at 2
    set_req(1, 3'd0, 4'd1, 4'd1);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    res_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 16'(res_valid), 16'd1);
    tick();
    rst       = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("in_rst_ready", 16'(req_ready), 16'd0);
    tick();
    rst       = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 16'(res_valid), 16'd0);
    check("post_rst_ready", 16'(req_ready), 16'b0001);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("post_rst_id", 16'(res_id), 16'd0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
